// File: rtl/switch_box_pkg.sv
// switch_box_pkg: shared encoding and sizing helpers for the switch box.
//   - source-select encoding: neighbour sides first (ascending, own side
//     skipped), then PE outputs, anything beyond that drives zero
//   - width helpers for the select field and the full config entry
//   - config entry field offsets (sel in the low bits, reg_en on top)
package switch_box_pkg;

    // Source-select encoding
    localparam int SRC_SIDE_BASE = 0;

    function automatic int pe_sel_base(input int num_sides);
        return num_sides - 1;
    endfunction

    function automatic int nsrc_f(input int num_sides, input int num_pe);
        return num_sides - 1 + num_pe;
    endfunction

    // One extra code point beyond the real sources so there is always an
    // encoding that selects zero.
    function automatic int sel_w_f(input int num_sides, input int num_pe);
        return $clog2(nsrc_f(num_sides, num_pe) + 1);
    endfunction

    function automatic int cfg_w_f(input int num_sides, input int num_pe);
        return sel_w_f(num_sides, num_pe) + 1;
    endfunction

    // Config entry field offsets
    localparam int CFG_SEL_LSB = 0;

    function automatic int cfg_reg_en_bit(input int num_sides, input int num_pe);
        return sel_w_f(num_sides, num_pe);
    endfunction

    // k-th neighbour side of side 'own', counting upward and skipping 'own'.
    function automatic int side_skip(input int k, input int own);
        return (k < own) ? k : k + 1;
    endfunction

endpackage

// File: rtl/sb_track_mux.sv
// sb_track_mux: one output track of the switch box.
//   Selects one of NSRC candidate sources (sel >= NSRC gives zero) and
//   optionally retimes it through a WIDTH-bit register that reloads every
//   cycle, so flipping reg_en never needs a refill sequence.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (clears the register)
//   srcs        : NSRC*WIDTH packed candidates, source i at [i*WIDTH +: WIDTH]
//   sel         : source select
//   reg_en      : 1 = registered output, 0 = combinational bypass
//   out         : routed track value
module sb_track_mux #(
    parameter int NSRC  = 4,
    parameter int WIDTH = 1,
    parameter int SEL_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NSRC*WIDTH-1:0] srcs,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  reg_en,
    output logic [WIDTH-1:0]      out
);

    logic [WIDTH-1:0] mux_val;
    logic [WIDTH-1:0] pipe_q;

    always_comb begin
        mux_val = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel == SEL_W'(i))
                mux_val = srcs[i*WIDTH +: WIDTH];
        end
    end

    // Loaded regardless of reg_en: on a 0->1 switch the register already
    // holds the value sampled in the commit cycle.
    always_ff @(posedge clk) begin
        if (reset)
            pipe_q <= '0;
        else
            pipe_q <= mux_val;
    end

    assign out = reg_en ? pipe_q : mux_val;

endmodule

// File: rtl/switch_box_pipe.sv
// switch_box_pipe: configurable switch box with per-output optional retiming.
//   Each output (side s, track t) picks a neighbour side's same track or a
//   PE output. Config is written into a shadow table and copied to the
//   active table on cfg_commit, so routing changes atomically.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   in_tracks    : side s track t at [(s*NUM_TRACKS+t)*WIDTH +: WIDTH]
//   out_tracks   : same packing as in_tracks
//   pe_out       : PE p at [p*WIDTH +: WIDTH]
//   cfg_valid    : config write request
//   cfg_ready    : write accepted when cfg_valid && cfg_ready (low on commit)
//   cfg_addr     : output index s*NUM_TRACKS+t
//   cfg_data     : {reg_en, sel}
//   cfg_commit   : copy shadow to active
//   cfg_err      : sticky, set by an accepted out-of-range write
//   cfg_rdata    : (SB_CFG_READBACK_EN only) active[cfg_addr], registered
//                  in cycles with cfg_valid=0
// Optional feature macro: SB_CFG_READBACK_EN
module switch_box_pipe
    import switch_box_pkg::*;
#(
    parameter  int NUM_SIDES  = 4,
    parameter  int NUM_TRACKS = 4,
    parameter  int WIDTH      = 1,
    parameter  int NUM_PE     = 1,
    localparam int NUM_OUT    = NUM_SIDES * NUM_TRACKS,
    localparam int NSRC       = nsrc_f(NUM_SIDES, NUM_PE),
    localparam int SEL_W      = sel_w_f(NUM_SIDES, NUM_PE),
    localparam int CFG_W      = cfg_w_f(NUM_SIDES, NUM_PE),
    // Wide enough to express index NUM_OUT, so an out-of-range write is
    // representable even when NUM_OUT is a power of two.
    localparam int ADDR_W     = $clog2(NUM_OUT + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_OUT*WIDTH-1:0] in_tracks,
    output logic [NUM_OUT*WIDTH-1:0] out_tracks,
    input  logic [NUM_PE*WIDTH-1:0]  pe_out,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [CFG_W-1:0]         cfg_data,
    input  logic                     cfg_commit,
    output logic                     cfg_err
`ifdef SB_CFG_READBACK_EN
    ,
    output logic [CFG_W-1:0]         cfg_rdata
`endif
);

    localparam int REN_BIT = cfg_reg_en_bit(NUM_SIDES, NUM_PE);
    localparam int PE_BASE = pe_sel_base(NUM_SIDES);

    logic [NUM_OUT-1:0][CFG_W-1:0] shadow;
    logic [NUM_OUT-1:0][CFG_W-1:0] active;
    logic                          cfg_wr;
    logic                          addr_bad;

    // Commit wins over a concurrent write; the write simply stalls.
    assign cfg_ready = ~cfg_commit;
    assign cfg_wr    = cfg_valid & cfg_ready;
    assign addr_bad  = (cfg_addr >= ADDR_W'(NUM_OUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow  <= '0;
            active  <= '0;
            cfg_err <= 1'b0;
        end else begin
            if (cfg_wr) begin
                if (addr_bad) begin
                    cfg_err <= 1'b1;
                end else begin
                    for (int i = 0; i < NUM_OUT; i++) begin
                        if (cfg_addr == ADDR_W'(i))
                            shadow[i] <= cfg_data;
                    end
                end
            end
            if (cfg_commit)
                active <= shadow;
        end
    end

`ifdef SB_CFG_READBACK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_rdata <= '0;
        end else if (!cfg_valid) begin
            cfg_rdata <= '0;
            for (int i = 0; i < NUM_OUT; i++) begin
                if (cfg_addr == ADDR_W'(i))
                    cfg_rdata <= active[i];
            end
        end
    end
`endif

    // Per-output candidate vectors: neighbour sides in ascending order
    // (own side skipped), then PE outputs.
    for (genvar s = 0; s < NUM_SIDES; s++) begin : g_side
        for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_track
            localparam int O = s * NUM_TRACKS + t;
            logic [NSRC*WIDTH-1:0] srcs;

            for (genvar k = 0; k < NUM_SIDES - 1; k++) begin : g_nbr
                localparam int KP = side_skip(k, s);
                assign srcs[(SRC_SIDE_BASE+k)*WIDTH +: WIDTH] =
                    in_tracks[(KP*NUM_TRACKS+t)*WIDTH +: WIDTH];
            end

            for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
                assign srcs[(PE_BASE+p)*WIDTH +: WIDTH] = pe_out[p*WIDTH +: WIDTH];
            end

            sb_track_mux #(
                .NSRC  (NSRC),
                .WIDTH (WIDTH),
                .SEL_W (SEL_W)
            ) u_mux (
                .clk    (clk),
                .reset  (reset),
                .srcs   (srcs),
                .sel    (active[O][CFG_SEL_LSB +: SEL_W]),
                .reg_en (active[O][REN_BIT]),
                .out    (out_tracks[O*WIDTH +: WIDTH])
            );
        end
    end

endmodule

// File: tb/tb_switch_box_pipe.sv
module tb_switch_box_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_tracks;
    logic [15:0] out_tracks;
    logic [0:0]  pe_out;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [4:0]  cfg_addr;
    logic [3:0]  cfg_data;
    logic        cfg_commit;
    logic        cfg_err;
`ifdef SB_CFG_READBACK_EN
    logic [3:0]  cfg_rdata;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    switch_box_pipe #(
        .NUM_SIDES  (4),
        .NUM_TRACKS (4),
        .WIDTH      (1),
        .NUM_PE     (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_tracks  (in_tracks),
        .out_tracks (out_tracks),
        .pe_out     (pe_out),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .cfg_err    (cfg_err)
`ifdef SB_CFG_READBACK_EN
        ,
        .cfg_rdata  (cfg_rdata)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_tracks = '0; pe_out = '0;
        cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", cfg_err); end
        checks++;
        if (out_tracks !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", out_tracks); end
    endtask

    task automatic test_default_route();
        in_tracks = 16'h0010; #1;
        checks++;
        if (out_tracks !== 16'h0001) begin errors++; $display("FAIL default_s1t0: got %h expected 0001", out_tracks); end
        in_tracks = 16'h000F; #1;
        checks++;
        if (out_tracks !== 16'hFFF0) begin errors++; $display("FAIL default_side0: got %h expected fff0", out_tracks); end
        in_tracks = '0; #1;
    endtask

    // addr0 <- pe, registered; invisible until commit, then via register
    task automatic test_shadow_commit();
        pe_out = 1'b1;
        cfg_valid = 1'b1; cfg_addr = 5'd0; cfg_data = 4'hB;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (out_tracks !== 16'h0000) begin errors++; $display("FAIL shadow_nocommit: got %h expected 0000", out_tracks); end
        tick(); tick();
        checks++;
        if (out_tracks !== 16'h0000) begin errors++; $display("FAIL shadow_hold: got %h expected 0000", out_tracks); end
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        checks++;
        if (out_tracks !== 16'h0000) begin errors++; $display("FAIL commit_reg_old: got %h expected 0000", out_tracks); end
        tick(); tick();
        checks++;
        if (out_tracks !== 16'h0001) begin errors++; $display("FAIL commit_reg_pe: got %h expected 0001", out_tracks); end
    endtask

    task automatic test_commit_stall();
        cfg_valid = 1'b1; cfg_commit = 1'b1; cfg_addr = 5'd1; cfg_data = 4'h3; #1;
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", cfg_ready); end
        tick();
        // second commit exposes any write leaked in the stall cycle
        cfg_valid = 1'b0;
        tick();
        cfg_commit = 1'b0;
        checks++;
        if (out_tracks !== 16'h0001) begin errors++; $display("FAIL stall_nowrite: got %h expected 0001", out_tracks); end
        cfg_valid = 1'b1; #1;
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL stall_retry_ready: got %b expected 1", cfg_ready); end
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (out_tracks !== 16'h0001) begin errors++; $display("FAIL retry_shadow: got %h expected 0001", out_tracks); end
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        checks++;
        if (out_tracks !== 16'h0003) begin errors++; $display("FAIL retry_commit: got %h expected 0003", out_tracks); end
    endtask

    task automatic test_bad_addr();
        cfg_valid = 1'b1; cfg_addr = 5'd16; cfg_data = 4'h7; #1;
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL bad_ready: got %b expected 1", cfg_ready); end
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_err !== 1'b1) begin errors++; $display("FAIL bad_err: got %b expected 1", cfg_err); end
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        checks++;
        if (out_tracks !== 16'h0003) begin errors++; $display("FAIL bad_shadow: got %h expected 0003", out_tracks); end
        tick(); tick(); tick();
        checks++;
        if (cfg_err !== 1'b1) begin errors++; $display("FAIL bad_err_sticky: got %b expected 1", cfg_err); end
    endtask

    task automatic test_sel_invalid();
        cfg_valid = 1'b1; cfg_addr = 5'd5; cfg_data = 4'h7;
        tick();
        cfg_valid = 1'b0; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        in_tracks = 16'hFFFF; #1;
        checks++;
        if (out_tracks !== 16'hFFDF) begin errors++; $display("FAIL sel7_ones: got %h expected ffdf", out_tracks); end
        in_tracks = 16'h0002; #1;
        checks++;
        if (out_tracks !== 16'h2203) begin errors++; $display("FAIL sel7_t1: got %h expected 2203", out_tracks); end
        in_tracks = '0; #1;
    endtask

    task automatic test_back_to_back();
        cfg_valid = 1'b1; cfg_addr = 5'd2; cfg_data = 4'h3;
        tick();
        cfg_addr = 5'd3;
        tick();
        cfg_valid = 1'b0; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        checks++;
        if (out_tracks !== 16'h000F) begin errors++; $display("FAIL b2b_out: got %h expected 000f", out_tracks); end
`ifdef SB_CFG_READBACK_EN
        cfg_addr = 5'd2;
        tick();
        checks++;
        if (cfg_rdata !== 4'h3) begin errors++; $display("FAIL rdata_addr2: got %h expected 3", cfg_rdata); end
        cfg_addr = 5'd16;
        tick();
        checks++;
        if (cfg_rdata !== 4'h0) begin errors++; $display("FAIL rdata_bad: got %h expected 0", cfg_rdata); end
`endif
    endtask

    task automatic test_reset_mid();
        cfg_valid = 1'b1; cfg_addr = 5'd15; cfg_data = 4'hB;
        tick();
        cfg_valid = 1'b0; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        tick();
        checks++;
        if (out_tracks !== 16'h800F) begin errors++; $display("FAIL midrun_reg: got %h expected 800f", out_tracks); end
        // reset must beat a concurrent write and a concurrent commit
        reset = 1'b1; cfg_valid = 1'b1; cfg_addr = 5'd0; cfg_data = 4'h7;
        tick();
        cfg_valid = 1'b0; cfg_commit = 1'b1;
        tick();
        reset = 1'b0; cfg_commit = 1'b0;
        tick();
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_err_clr: got %b expected 0", cfg_err); end
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", cfg_ready); end
        in_tracks = 16'h0010; #1;
        checks++;
        if (out_tracks !== 16'h0001) begin errors++; $display("FAIL rst_route_s1t0: got %h expected 0001", out_tracks); end
        in_tracks = 16'h000F; #1;
        checks++;
        if (out_tracks !== 16'hFFF0) begin errors++; $display("FAIL rst_route_side0: got %h expected fff0", out_tracks); end
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        in_tracks = 16'h0010; #1;
        checks++;
        if (out_tracks !== 16'h0001) begin errors++; $display("FAIL rst_shadow_clean: got %h expected 0001", out_tracks); end
    endtask

    initial begin
        test_reset();
        test_default_route();
        test_shadow_commit();
        test_commit_stall();
        test_bad_addr();
        test_sel_invalid();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
